// File: rtl/serial_subtractor.sv
// Bit-serial borrow-ripple subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Operands are captured in IDLE, WIDTH RUN cycles ripple the borrow through a single
// full-subtractor cell, and the result is held in DONE until the consumer takes it.
// Optional build macro SUB_OVF_EN adds a registered signed-overflow output 'ovf'.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Counter needs at least one bit even when WIDTH=1 (RUN is then a single cycle).
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sr, sr_nxt;
  logic [WIDTH:0]   sr_cat;
  logic [CW-1:0]    cnt;
  logic             br, br_nxt, d, last;

  // Full-subtractor cell on the current LSBs and the registered borrow.
  assign d      = sa[0] ^ sb[0] ^ br;
  assign br_nxt = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br);
  assign last   = (cnt == CW'(WIDTH - 1));

  // Result bits enter from the MSB side so the LSB lands at bit 0 after WIDTH shifts.
  assign sr_cat = {d, sr};
  assign sr_nxt = sr_cat[WIDTH:1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, serial shift, and result load on the final RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      sr   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
`ifdef SUB_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa  <= a;
            sb  <= b;
            br  <= bin;
            sr  <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_nxt;
          sr  <= sr_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            diff <= sr_nxt;
            bout <= br_nxt;
`ifdef SUB_OVF_EN
            // Borrow into the MSB vs borrow out of it: mismatch means signed overflow.
            ovf  <= br ^ br_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: scoreboard of expected results pushed at
// operand acceptance, popped and compared when out_valid rises.
module tb_serial_subtractor;

  localparam int W = 4;
  localparam logic [W-1:0] MASK = '1;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int tests = 0;
  int fails = 0;
  exp_t sb_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
`ifdef SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model written from the arithmetic definition, not the bit-serial cell.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    exp_t e;
    int sx, sy, res;
    e.diff = W'((int'(x) - int'(y) - int'(bi)) & int'(MASK));
    e.bout = (int'(x) < int'(y) + int'(bi));
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    res = sx - sy - int'(bi);
    e.ovf = (res < -(1 << (W-1))) || (res > (1 << (W-1)) - 1);
    return e;
  endfunction

  // Present operands for one accepting edge; expected result goes on the scoreboard.
  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    @(negedge clk);
    a = x; b = y; bin = bi; in_valid = 1'b1;
    sb_q.push_back(model(x, y, bi));
    @(negedge clk);
    in_valid = 1'b0;
    a = ~x; b = ~y; bin = ~bi;
  endtask

  // Wait (bounded) for out_valid, check latency, pop and compare the scoreboard entry.
  task automatic collect(input string tag);
    int n = 0;
    exp_t e;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, W);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_diff"}, diff, e.diff);
      check({tag, "_bout"}, bout, e.bout);
`ifdef SUB_OVF_EN
      check({tag, "_ovf"}, ovf, e.ovf);
`endif
    end
  endtask

  task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic bi, input logic rdy_early);
    out_ready = rdy_early;
    drive(x, y, bi);
    collect(tag);
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_consumed_ov"}, out_valid, 0);
    check({tag, "_consumed_ir"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] hold_d;
    // Reset state
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, mix of early and late out_ready
    op("a9_b3",    4'd9,  4'd3,  1'b0, 1'b0);
    op("a3_b9",    4'd3,  4'd9,  1'b0, 1'b1);
    op("a0_b0_bi", 4'd0,  4'd0,  1'b1, 1'b0);
    op("a15_b15",  4'd15, 4'd15, 1'b0, 1'b1);
    check("idle_diff_held", diff, 0);
    op("ovf_m8_1", 4'd8,  4'd1,  1'b0, 1'b0);
    op("ovf_5_3",  4'd5,  4'd3,  1'b0, 1'b1);
    op("ovf_7_m1", 4'd7,  4'd15, 1'b0, 1'b0);

    // Back-pressure: in_valid pulses in RUN/DONE must be ignored
    out_ready = 1'b0;
    drive(4'd12, 4'd5, 1'b0);
    check("bp_run_in_ready", in_ready, 0);
    a = 4'd1; b = 4'd1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    begin
      int n = 1;
      exp_t e;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("bp_latency", n, W);
      e = sb_q.pop_front();
      for (int i = 0; i < 5; i++) begin
        in_valid = (i == 2);
        a = 4'd3; b = 4'd1;
        check("bp_hold_diff", diff, e.diff);
        check("bp_hold_bout", bout, e.bout);
        check("bp_hold_ov", out_valid, 1);
        check("bp_hold_ir", in_ready, 0);
        @(negedge clk);
      end
      in_valid = 1'b0;
      check("bp_final_diff", diff, 4'd7);
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ov", out_valid, 0);
      check("bp_release_ir", in_ready, 1);
      out_ready = 1'b0;
      // The ignored pulses must not have started another operation
      repeat (W + 2) @(negedge clk);
      check("bp_no_ghost_op", out_valid, 0);
      check("bp_diff_kept", diff, 4'd7);
    end

    // Reset two cycles into RUN discards the operation immediately
    @(negedge clk);
    a = 4'd1; b = 4'd2; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ov", out_valid, 0);
    check("mid_rst_diff", diff, 0);
    check("mid_rst_bout", bout, 0);
    check("mid_rst_ir", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    op("post_rst_7_2", 4'd7, 4'd2, 1'b0, 1'b0);

    // A few random operations
    for (int i = 0; i < 6; i++) begin
      op("rand", W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
